rc4_ksa_engine: RTL

RC4_KSA_ENGINE -- requirements
Module: rc4_ksa_engine

---
 rtl/rc4_pkg.sv | 26 ++
 rtl/rc4_key_mux.sv | 20 ++
 rtl/rc4_ksa_engine.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/rc4_pkg.sv
// Shared types for the RC4 key-scheduling engine: FSM state encoding and
// operation modes.
package rc4_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_INIT_WR = 4'd1,
    ST_RD_I    = 4'd2,
    ST_WAIT_I  = 4'd3,
    ST_RD_J    = 4'd4,
    ST_WAIT_J  = 4'd5,
    ST_WR_I    = 4'd6,
    ST_WR_J    = 4'd7,
    ST_FINISH  = 4'd8
  } rc4_state_e;

  typedef enum logic [1:0] {
    MODE_INIT     = 2'd0,
    MODE_SHUFFLE  = 2'd1,
    MODE_BOTH     = 2'd2,
    MODE_BOTH_ALT = 2'd3
  } rc4_mode_e;

  localparam int RC4_MAX_READ_LATENCY = 3;

endpackage

// File: rtl/rc4_key_mux.sv
// Selects key byte k from the packed key vector (byte 0 in the LSBs).
// Indices at or beyond MAX_KEY_BYTES return zero.
module rc4_key_mux #(
  parameter int DATA_WIDTH    = 8,
  parameter int MAX_KEY_BYTES = 16,
  parameter int K_WIDTH       = 5
) (
  input  logic [MAX_KEY_BYTES*DATA_WIDTH-1:0] key,
  input  logic [K_WIDTH-1:0]                  k,
  output logic [DATA_WIDTH-1:0]               key_byte
);

  always_comb begin
    key_byte = '0;
    for (int b = 0; b < MAX_KEY_BYTES; b++) begin
      if (k == K_WIDTH'(b)) key_byte = key[b*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: rtl/rc4_ksa_engine.sv
// RC4 key-scheduling engine driving an external synchronous S-box RAM.
// Handshake: start is a one-cycle request honoured only in IDLE; done/error are one-cycle result pulses.
module rc4_ksa_engine
  import rc4_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 8,
  parameter int MAX_KEY_BYTES = 16,
  parameter int READ_LATENCY  = 1
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                start,
  input  logic [1:0]                          mode,
  input  logic [$clog2(MAX_KEY_BYTES+1)-1:0]  key_len,
  input  logic [MAX_KEY_BYTES*DATA_WIDTH-1:0] key,
  input  logic                                abort,
  input  logic [DATA_WIDTH-1:0]               ram_rdata,
  output logic [ADDR_WIDTH-1:0]               ram_addr,
  output logic [DATA_WIDTH-1:0]               ram_wdata,
  output logic                                ram_we,
  output logic                                busy,
  output logic                                done,
  output logic                                error,
  output logic [ADDR_WIDTH-1:0]               i_tap,
  output logic [ADDR_WIDTH-1:0]               j_tap,
  output logic [3:0]                          state_tap
);

  localparam int KW = $clog2(MAX_KEY_BYTES+1);

  if (DATA_WIDTH < ADDR_WIDTH) begin : g_bad_width
    $error("rc4_ksa_engine: DATA_WIDTH must be >= ADDR_WIDTH");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > RC4_MAX_READ_LATENCY) begin : g_bad_latency
    $error("rc4_ksa_engine: READ_LATENCY must be 1..3");
  end

  rc4_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] i_q, i_d, j_q, j_d;
  logic [KW-1:0]         k_q, k_d, key_len_q, key_len_d;
  logic                  shuffle_q, shuffle_d;
  logic [DATA_WIDTH-1:0] si_q, si_d, sj_q, sj_d;
  logic [1:0]            wait_q, wait_d;
  logic                  armed_q, armed_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
  logic                  ram_we_q, ram_we_d;
  logic                  busy_q, busy_d, done_q, done_d, error_q, error_d;

  logic [DATA_WIDTH-1:0] key_byte;
  logic [ADDR_WIDTH-1:0] i_inc, j_sum;
  logic                  wait_last, bad_len;

  rc4_key_mux #(
    .DATA_WIDTH   (DATA_WIDTH),
    .MAX_KEY_BYTES(MAX_KEY_BYTES),
    .K_WIDTH      (KW)
  ) u_key_mux (
    .key     (key),
    .k       (k_q),
    .key_byte(key_byte)
  );

  assign i_inc     = i_q + 1'b1;
  assign j_sum     = j_q + ram_rdata[ADDR_WIDTH-1:0] + key_byte[ADDR_WIDTH-1:0];
  assign wait_last = (wait_q == 2'(READ_LATENCY-1));
  assign bad_len   = (key_len == '0) || (key_len > KW'(MAX_KEY_BYTES));

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    key_len_d   = key_len_q;
    shuffle_d   = shuffle_q;
    si_d        = si_q;
    sj_d        = sj_q;
    wait_d      = wait_q;
    armed_d     = 1'b1;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;
    done_d      = 1'b0;
    error_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // armed_q holds off the very first edge after reset release.
        if (start && !abort && armed_q) begin
          if (mode != MODE_INIT && bad_len) begin
            error_d = 1'b1;
          end else begin
            key_len_d  = key_len;
            shuffle_d  = (mode != MODE_INIT);
            i_d        = '0;
            j_d        = '0;
            k_d        = '0;
            ram_addr_d = '0;
            if (mode == MODE_SHUFFLE) begin
              state_d = ST_RD_I;
            end else begin
              state_d     = ST_INIT_WR;
              ram_wdata_d = '0;
              ram_we_d    = 1'b1;
            end
          end
        end
      end
      ST_INIT_WR: begin
        if (i_q == '1) begin
          i_d = '0;
          state_d = shuffle_q ? ST_RD_I : ST_FINISH;
          ram_addr_d = '0;
        end else begin
          i_d         = i_inc;
          ram_addr_d  = i_inc;
          ram_wdata_d = DATA_WIDTH'(i_inc);
          ram_we_d    = 1'b1;
        end
      end
      ST_RD_I: begin
        state_d = ST_WAIT_I;
        wait_d  = '0;
      end
      ST_WAIT_I: begin
        if (wait_last) begin
          si_d       = ram_rdata;
          j_d        = j_sum;
          ram_addr_d = j_sum;
          state_d    = ST_RD_J;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_RD_J: begin
        state_d = ST_WAIT_J;
        wait_d  = '0;
      end
      ST_WAIT_J: begin
        if (wait_last) begin
          sj_d        = ram_rdata;
          ram_addr_d  = i_q;
          ram_wdata_d = ram_rdata;
          ram_we_d    = 1'b1;
          state_d     = ST_WR_I;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_WR_I: begin
        ram_addr_d  = j_q;
        ram_wdata_d = si_q;
        ram_we_d    = 1'b1;
        state_d     = ST_WR_J;
      end
      ST_WR_J: begin
        k_d = (k_q == KW'(key_len_q - 1'b1)) ? '0 : k_q + 1'b1;
        if (i_q == '1) begin
          state_d = ST_FINISH;
        end else begin
          i_d        = i_inc;
          ram_addr_d = i_inc;
          state_d    = ST_RD_I;
        end
      end
      ST_FINISH: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over everything; the write presented this cycle still lands.
    if (abort && state_q != ST_IDLE) begin
      state_d  = ST_IDLE;
      ram_we_d = 1'b0;
      done_d   = 1'b0;
      error_d  = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      key_len_q   <= '0;
      shuffle_q   <= 1'b0;
      si_q        <= '0;
      sj_q        <= '0;
      wait_q      <= '0;
      armed_q     <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      key_len_q   <= key_len_d;
      shuffle_q   <= shuffle_d;
      si_q        <= si_d;
      sj_q        <= sj_d;
      wait_q      <= wait_d;
      armed_q     <= armed_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_we    = ram_we_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign i_tap     = i_q;
  assign j_tap     = j_q;
  assign state_tap = state_q;

endmodule
